// File: rtl/div_pkg.sv
// Shared types for the radix-2 sequential divider: FSM state encoding and
// the iteration-counter width helper.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // The counter must reach WIDTH itself, hence WIDTH+1 distinct values.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift one dividend bit
// into the partial remainder, subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;
  logic           unused_rem_msb;

  // The partial remainder is always below the divisor, so its top bit is
  // zero on entry and only the shifted value needs the extra bit.
  assign unused_rem_msb = rem[WIDTH];
  assign shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign diff     = shifted - {1'b0, divisor};
  assign fits     = (shifted >= {1'b0, divisor});
  assign rem_next = fits ? diff : shifted;
  assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/radix2_seq_divider.sv
// Parametrised one-bit-per-clock restoring divider with load/ready handshake.
// Optional divide-by-zero flag port dz is enabled by defining DIV_ZERO_FLAG_EN.
module radix2_seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic             ready,
  output logic [WIDTH-1:0] QUOTN,
  output logic [WIDTH-1:0] REMDR
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic             dz
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [WIDTH:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] dividend;
  logic           neg_q;
  logic           neg_r;
  logic           zero_div;

  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             d1_neg;
  logic             d2_neg;
  logic [WIDTH-1:0] d1_mag;
  logic [WIDTH-1:0] d2_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign d1_neg = SIGNED && d1[WIDTH-1];
  assign d2_neg = SIGNED && d2[WIDTH-1];
  assign d1_mag = d1_neg ? -d1 : d1;
  assign d2_mag = d2_neg ? -d2 : d2;

  // Divide-by-zero bypasses sign fix-up: all-ones quotient, raw dividend back.
  assign q_fix = zero_div ? '1 : (neg_q ? -quo : quo);
  assign r_fix = zero_div ? dividend : (neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0]);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // A load in any state restarts; CALC spends WIDTH cycles iterating plus one
  // cycle at cnt==WIDTH where the fixed-up result is committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      dividend <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      zero_div <= 1'b0;
      ready    <= 1'b0;
      QUOTN    <= '0;
      REMDR    <= '0;
`ifdef DIV_ZERO_FLAG_EN
      dz       <= 1'b0;
`endif
    end else begin
      ready <= 1'b0;
      if (load) begin
        state    <= CALC;
        cnt      <= '0;
        rem      <= '0;
        quo      <= d1_mag;
        divisor  <= d2_mag;
        dividend <= d1;
        neg_q    <= d1_neg ^ d2_neg;
        neg_r    <= d1_neg;
        zero_div <= (d2 == '0);
      end else begin
        case (state)
          IDLE: ;
          CALC: begin
            if (cnt == LAST) begin
              state <= DONE;
              ready <= 1'b1;
              QUOTN <= q_fix;
              REMDR <= r_fix;
`ifdef DIV_ZERO_FLAG_EN
              dz    <= zero_div;
`endif
            end else begin
              rem <= rem_next;
              quo <= quo_next;
              cnt <= cnt + 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
